game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
- Frame-rate game sequencer for the VGA scene.
- Owns the screen state, the panda's vertical position and velocity, the X positions of the four tube pairs, and the score.
- Its outputs drive the per-object existence/pixel generators and the final pixel priority mux: state 1 = start screen, 2 = play, 3 = game-over black screen.
- All motion updates happen once per frame on frame_tick.

Parameters:
- H_RES, 640, visible width in pixels.
- V_RES, 480, visible height in pixels.
- TUBE_SPACING, 160, horizontal pitch between consecutive tubes.
- SCROLL_STEP, 2, pixels tubes move left per frame; must evenly divide H_RES, TUBE_SPACING and PANDA_X.
- PANDA_X, 160, fixed left edge of the panda, used for scoring.
- PANDA_H, 32, panda height.
- GRAVITY, 1, velocity increment per frame.
- FLAP_VEL, 8, upward speed loaded on a flap.
- MAX_FALL, 8, maximum downward velocity.
- OVER_FRAMES, 120, frames the game-over screen is held before restart is accepted.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- frame_tick  in  1  one-cycle pulse per frame, at start of vertical blank.
- btn_start  in  1  debounced one-cycle start pulse.
- btn_flap  in  1  debounced one-cycle flap pulse.
- hit  in  1  panda/tube pixel overlap during the active area.
- state  out  2  0 INIT, 1 START, 2 PLAY, 3 OVER.
- panda_y  out  10  panda top edge.
- tube_x0, tube_x1, tube_x2, tube_x3  out  11 each  tube left edges.
- score  out  8  tubes passed, saturating.

Behaviour:

Reset (rst high at a clk edge):
- state=0, panda_y=V_RES/2 (240), velocity=0, score=0.
- tube_xi = H_RES + i*TUBE_SPACING (640, 800, 960, 1120).
- flap_pend=0, over_cnt=0.
- Reset mid-game behaves identically.

Load:
- "Load" means re-apply all of the reset values above except state.

INIT state:
- Moves to START on the next cycle unconditionally.

START state:
- Outputs are held.
- btn_start=1 -> PLAY next cycle, with a load in the same cycle.
- btn_flap and hit are ignored.

PLAY state:
- btn_flap sets flap_pend; it stays set until consumed.
- hit=1 in any cycle -> OVER next cycle.
  - Positions and score freeze at their current values.
  - hit takes priority over a coincident frame_tick: no motion update occurs.
- On frame_tick with hit=0, all updates are registered together in one cycle:
  - Velocity: if flap_pend or btn_flap (same cycle counts), velocity = -FLAP_VEL and flap_pend clears. Otherwise velocity = min(velocity + GRAVITY, MAX_FALL). Velocity is signed, at least 6 bits.
  - panda_y: new = panda_y + new velocity.
    - Clamped to 0 at the top; no penalty for hitting the top.
    - If new >= V_RES-PANDA_H (448): panda_y = 448 and state -> OVER.
  - Tubes: if tube_xi < SCROLL_STEP, then tube_xi = tube_xi + 4*TUBE_SPACING - SCROLL_STEP (wrap). Otherwise tube_xi = tube_xi - SCROLL_STEP.
  - Score: for each tube whose new tube_xi == PANDA_X, score += 1, saturating at 255.
    - Spacing guarantees at most one such tube per frame.

OVER state:
- over_cnt increments on each frame_tick, saturating at OVER_FRAMES.
- btn_start while over_cnt < OVER_FRAMES is ignored.
- btn_start once over_cnt == OVER_FRAMES -> START next cycle, with a load and over_cnt=0.
- score is held through OVER and cleared by the load.

General:
- Outputs are registered; no combinational path from inputs to outputs.
- State 0 never persists beyond one cycle.

Test Plan:
1. Reset -> state 0, one cycle later state 1; panda_y=240; tubes 640/800/960/1120; score 0.
2. btn_start, then one frame_tick without a flap -> state 2, velocity 1, panda_y 241, tube_x0 638. Next tick with a flap -> velocity -8, panda_y 233.
3. 240 frame_ticks in PLAY with a flap every 16 ticks -> tube_x0=160 and score=1 on tick 240.
4. Force tube_x0=0, then one tick -> tube_x0=638.
5. No flaps from panda_y=240 -> state 3 when y reaches 448, panda_y held at 448. Then btn_start at over tick 119 is ignored; btn_start after tick 120 -> state 1 with positions reloaded.
6. hit and frame_tick in the same PLAY cycle -> state 3 next cycle, with panda_y/tube_x/score unchanged. rst asserted in PLAY -> all reset values in the next cycle.

Source files
------------

// File: rtl/game_flow_ctrl_if.sv
// Bundle between the game sequencer and the scene: frame/button/collision
// inputs in, screen state and object positions out.
interface game_flow_ctrl_if;
   logic        frame_tick;
   logic        btn_start;
   logic        btn_flap;
   logic        hit;
   logic [1:0]  state;
   logic [9:0]  panda_y;
   logic [10:0] tube_x0;
   logic [10:0] tube_x1;
   logic [10:0] tube_x2;
   logic [10:0] tube_x3;
   logic [7:0]  score;

   modport master (
      input  frame_tick, btn_start, btn_flap, hit,
      output state, panda_y, tube_x0, tube_x1, tube_x2, tube_x3, score
   );

   modport slave (
      output frame_tick, btn_start, btn_flap, hit,
      input  state, panda_y, tube_x0, tube_x1, tube_x2, tube_x3, score
   );
endinterface

// File: rtl/game_flow_ctrl.sv
// Frame-rate game sequencer: screen state, panda motion, tube scrolling and
// score, all advanced once per frame_tick.
module game_flow_ctrl #(
   parameter int H_RES        = 640,
   parameter int V_RES        = 480,
   parameter int TUBE_SPACING = 160,
   parameter int SCROLL_STEP  = 2,
   parameter int PANDA_X      = 160,
   parameter int PANDA_H      = 32,
   parameter int GRAVITY      = 1,
   parameter int FLAP_VEL     = 8,
   parameter int MAX_FALL     = 8,
   parameter int OVER_FRAMES  = 120
) (
   input  logic              clk,
   input  logic              rst,
   game_flow_ctrl_if.master  gf
);

   typedef enum logic [1:0] {
      S_INIT  = 2'd0,
      S_START = 2'd1,
      S_PLAY  = 2'd2,
      S_OVER  = 2'd3
   } state_e;

   localparam logic [9:0]         Y_HOME   = 10'(V_RES / 2);
   localparam logic [9:0]         Y_FLOOR  = 10'(V_RES - PANDA_H);
   localparam logic signed [5:0]  V_FLAP   = 6'(-FLAP_VEL);
   localparam logic signed [5:0]  V_MAX    = 6'(MAX_FALL);
   localparam logic signed [5:0]  V_GRAV   = 6'(GRAVITY);
   localparam logic [10:0]        STEP     = 11'(SCROLL_STEP);
   localparam logic [10:0]        WRAP_ADD = 11'(4 * TUBE_SPACING - SCROLL_STEP);
   localparam logic [10:0]        SCORE_X  = 11'(PANDA_X);
   localparam logic [6:0]         OVER_MAX = 7'(OVER_FRAMES);

   state_e               state_q, state_d;
   logic [9:0]           y_q, y_d;
   logic signed [5:0]    vel_q, vel_d;
   logic [10:0]          tube_q [4];
   logic [10:0]          tube_d [4];
   logic [7:0]           score_q, score_d;
   logic                 pend_q, pend_d;
   logic [6:0]           cnt_q, cnt_d;

   // Candidate per-frame motion, committed only by a clean PLAY frame_tick.
   logic signed [5:0]    vel_new;
   logic signed [5:0]    vel_fall;
   logic [11:0]          y_wide;
   logic [9:0]           y_new;
   logic                 floor_hit;
   logic [10:0]          tube_new [4];
   logic                 tube_pass;

   always_comb begin
      vel_fall = vel_q + V_GRAV;
      if (pend_q || gf.btn_flap) begin
         vel_new = V_FLAP;
      end else if (vel_fall > V_MAX) begin
         vel_new = V_MAX;
      end else begin
         vel_new = vel_fall;
      end

      y_wide    = {2'b00, y_q} + {{6{vel_new[5]}}, vel_new};
      floor_hit = !y_wide[11] && (y_wide >= {2'b00, Y_FLOOR});
      if (y_wide[11]) begin
         y_new = '0;
      end else if (floor_hit) begin
         y_new = Y_FLOOR;
      end else begin
         y_new = y_wide[9:0];
      end

      tube_pass = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (tube_q[i] < STEP) begin
            tube_new[i] = tube_q[i] + WRAP_ADD;
         end else begin
            tube_new[i] = tube_q[i] - STEP;
         end
         tube_pass = tube_pass | (tube_new[i] == SCORE_X);
      end
   end

   always_comb begin
      // NOTE: every next-state signal is defaulted first so no path can infer a latch.
      state_d = state_q;
      y_d     = y_q;
      vel_d   = vel_q;
      tube_d  = tube_q;
      score_d = score_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         S_INIT: state_d = S_START;

         S_START: begin
            if (gf.btn_start) begin
               state_d = S_PLAY;
            end
         end

         S_PLAY: begin
            pend_d = pend_q | gf.btn_flap;
            if (gf.hit) begin
               state_d = S_OVER;
            end else if (gf.frame_tick) begin
               vel_d  = vel_new;
               y_d    = y_new;
               tube_d = tube_new;
               pend_d = 1'b0;
               if (tube_pass && score_q != 8'hFF) begin
                  score_d = score_q + 8'd1;
               end
               if (floor_hit) begin
                  state_d = S_OVER;
               end
            end
         end

         S_OVER: begin
            if (gf.frame_tick && cnt_q != OVER_MAX) begin
               cnt_d = cnt_q + 7'd1;
            end
            if (gf.btn_start && cnt_q == OVER_MAX) begin
               state_d = S_START;
            end
         end

         default: state_d = S_INIT;
      endcase

      // Any transition out of START or OVER starts a fresh round.
      if ((state_q == S_START && state_d == S_PLAY) ||
          (state_q == S_OVER  && state_d == S_START)) begin
         y_d     = Y_HOME;
         vel_d   = '0;
         score_d = '0;
         pend_d  = 1'b0;
         cnt_d   = '0;
         for (int i = 0; i < 4; i++) begin
            tube_d[i] = 11'(H_RES + i * TUBE_SPACING);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_INIT;
         y_q     <= Y_HOME;
         vel_q   <= '0;
         score_q <= '0;
         pend_q  <= 1'b0;
         cnt_q   <= '0;
         for (int i = 0; i < 4; i++) begin
            tube_q[i] <= 11'(H_RES + i * TUBE_SPACING);
         end
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         vel_q   <= vel_d;
         score_q <= score_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         tube_q  <= tube_d;
      end
   end

   assign gf.state   = state_q;
   assign gf.panda_y = y_q;
   assign gf.tube_x0 = tube_q[0];
   assign gf.tube_x1 = tube_q[1];
   assign gf.tube_x2 = tube_q[2];
   assign gf.tube_x3 = tube_q[3];
   assign gf.score   = score_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: reset, start, flight, scoring, tube wrap,
// floor death, game-over hold, hit priority and mid-game reset.
module tb_game_flow_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   game_flow_ctrl_if gf ();

   game_flow_ctrl dut (
      .clk (clk),
      .rst (rst),
      .gf  (gf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock with the given input pulses, sampled 1ns after the edge.
   task automatic cyc(input bit ft, input bit st, input bit fl, input bit ht);
      gf.frame_tick = ft;
      gf.btn_start  = st;
      gf.btn_flap   = fl;
      gf.hit        = ht;
      @(posedge clk);
      #1;
      gf.frame_tick = 1'b0;
      gf.btn_start  = 1'b0;
      gf.btn_flap   = 1'b0;
      gf.hit        = 1'b0;
   endtask

   task automatic tick(input bit fl);
      cyc(1'b1, 1'b0, fl, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Reset, let INIT pass, press start: leaves the DUT in PLAY.
   task automatic restart_play();
      rst = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      gf.frame_tick = 1'b0;
      gf.btn_start  = 1'b0;
      gf.btn_flap   = 1'b0;
      gf.hit        = 1'b0;

      // Reset values, INIT lasts one cycle, START ignores flap/hit.
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      check("rst_state", gf.state, 0);
      check("rst_y", gf.panda_y, 240);
      check("rst_x0", gf.tube_x0, 640);
      check("rst_x1", gf.tube_x1, 800);
      check("rst_x2", gf.tube_x2, 960);
      check("rst_x3", gf.tube_x3, 1120);
      check("rst_score", gf.score, 0);
      rst = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      check("init_to_start", gf.state, 1);
      cyc(1'b1, 1'b0, 1'b1, 1'b1);
      check("start_hold_state", gf.state, 1);
      check("start_hold_y", gf.panda_y, 240);
      check("start_hold_x0", gf.tube_x0, 640);

      // Start and the first two frames.
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      check("play_state", gf.state, 2);
      tick(1'b0);
      check("t1_y", gf.panda_y, 241);
      check("t1_x0", gf.tube_x0, 638);
      tick(1'b1);
      check("t2_y", gf.panda_y, 233);
      check("t2_x0", gf.tube_x0, 636);

      // Long flight, flap on every tick t with t%16 == 2.
      for (int t = 3; t <= 321; t++) begin
         tick((t % 16) == 2);
         if (t == 239) check("t239_score", gf.score, 0);
         if (t == 240) begin
            check("t240_x0", gf.tube_x0, 160);
            check("t240_score", gf.score, 1);
            check("t240_y", gf.panda_y, 114);
            check("t240_state", gf.state, 2);
         end
         if (t == 320) begin
            check("t320_x0", gf.tube_x0, 0);
            check("t320_x1", gf.tube_x1, 160);
            check("t320_score", gf.score, 2);
            check("t320_y", gf.panda_y, 74);
         end
      end
      check("wrap_x0", gf.tube_x0, 638);
      check("wrap_x3", gf.tube_x3, 478);
      check("wrap_score", gf.score, 2);
      check("wrap_y", gf.panda_y, 81);

      // Hit without a tick: OVER, everything frozen, early start ignored.
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      check("hit_state", gf.state, 3);
      tick(1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      check("hit_early_start", gf.state, 3);
      check("hit_score", gf.score, 2);
      check("hit_y", gf.panda_y, 81);
      check("hit_x0", gf.tube_x0, 638);

      // Free fall to the floor, then the game-over hold.
      restart_play();
      check("ff_reload_x0", gf.tube_x0, 640);
      check("ff_reload_score", gf.score, 0);
      for (int t = 1; t <= 30; t++) begin
         tick(1'b0);
         if (t == 29) begin
            check("t29_y", gf.panda_y, 444);
            check("t29_state", gf.state, 2);
         end
      end
      check("floor_state", gf.state, 3);
      check("floor_y", gf.panda_y, 448);
      check("floor_x0", gf.tube_x0, 580);
      for (int t = 1; t <= 119; t++) tick(1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      check("over119_start", gf.state, 3);
      check("over119_y", gf.panda_y, 448);
      check("over119_x0", gf.tube_x0, 580);
      tick(1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      check("over120_state", gf.state, 1);
      check("over120_y", gf.panda_y, 240);
      check("over120_x0", gf.tube_x0, 640);
      check("over120_x3", gf.tube_x3, 1120);

      // A restarted round must again wait the full hold.
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      for (int t = 1; t <= 30; t++) tick(1'b0);
      check("round2_over", gf.state, 3);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      check("round2_hold", gf.state, 3);

      // Flap pulse between ticks is remembered; hit beats a coincident tick.
      restart_play();
      tick(1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      check("pend_hold_y", gf.panda_y, 241);
      check("pend_hold_state", gf.state, 2);
      tick(1'b0);
      check("pend_y", gf.panda_y, 233);
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      check("hit_tick_state", gf.state, 3);
      check("hit_tick_y", gf.panda_y, 233);
      check("hit_tick_x0", gf.tube_x0, 636);
      check("hit_tick_score", gf.score, 0);

      // Reset in the middle of play.
      restart_play();
      tick(1'b0);
      tick(1'b0);
      check("pre_rst_y", gf.panda_y, 243);
      rst = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      check("mid_rst_state", gf.state, 0);
      check("mid_rst_y", gf.panda_y, 240);
      check("mid_rst_x0", gf.tube_x0, 640);
      check("mid_rst_x3", gf.tube_x3, 1120);
      check("mid_rst_score", gf.score, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
